// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, arbiter state and owner encodings for the cache/memory arbiter
package mem_arbiter_pkg;
    localparam int WORD_SIZE  = 16;
    localparam int LINE_WORDS = 4;
    localparam int BEAT_BITS  = 2;

    typedef enum logic [1:0] {
        IDLE,
        XFER_I,
        XFER_D_RD,
        XFER_D_WR
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin owner of the single memory port, sequencing line bursts for I and D caches
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_grant,
    output logic                 i_rvalid,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_done,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_grant,
    output logic                 d_rvalid,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_done,
    output logic [BEAT_BITS-1:0] beat,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack
);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_WORDS - 1);
    localparam logic [WORD_SIZE-1:0] LINE_MASK = ~WORD_SIZE'(LINE_WORDS - 1);

    arb_state_t             state, state_nx;
    owner_t                 last_owner, owner_nx;
    logic [BEAT_BITS-1:0]   beat_nx;
    logic [WORD_SIZE-1:0]   base, base_nx;
    logic                   last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            beat       <= '0;
            base       <= '0;
            last_owner <= OWNER_D;
        end else begin
            state      <= state_nx;
            beat       <= beat_nx;
            base       <= base_nx;
            last_owner <= owner_nx;
        end
    end

    // A tie goes to whichever side did not own the previous burst.
    always_comb begin
        state_nx = state;
        beat_nx  = beat;
        base_nx  = base;
        owner_nx = last_owner;
        if (state == IDLE) begin
            beat_nx = '0;
            if (i_req && (!d_req || last_owner == OWNER_D)) begin
                state_nx = XFER_I;
                base_nx  = i_addr;
                owner_nx = OWNER_I;
            end else if (d_req) begin
                state_nx = d_we ? XFER_D_WR : XFER_D_RD;
                base_nx  = d_addr;
                owner_nx = OWNER_D;
            end
        end else if (mem_ack) begin
            beat_nx  = last ? '0 : beat + 1'b1;
            state_nx = last ? IDLE : state;
        end
    end

    assign i_grant   = state == XFER_I;
    assign d_grant   = state == XFER_D_RD || state == XFER_D_WR;
    assign mem_read  = state == XFER_I || state == XFER_D_RD;
    assign mem_write = state == XFER_D_WR;
    assign mem_addr  = (i_grant || d_grant) ? ((base & LINE_MASK) | WORD_SIZE'(beat)) : '0;
    assign mem_wdata = mem_write ? d_wdata : '0;
    assign last      = mem_ack && beat == LAST_BEAT;
    assign i_rvalid  = i_grant && mem_ack;
    assign i_rdata   = i_rvalid ? mem_rdata : '0;
    assign d_rvalid  = state == XFER_D_RD && mem_ack;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign i_done    = i_grant && last;
    assign d_done    = d_grant && last;
endmodule
